// File: rtl/alu_md_sequencer.sv
// alu_md_sequencer: multi-cycle unsigned multiply/divide sequencer.
// Each iteration borrows the execute-stage ALU: ADD for shift-add multiply,
// SUB for restoring divide. Optional build macro: MDSEQ_EARLY_EXIT_EN
// (multiply finishes as soon as the remaining multiplier becomes zero).
module alu_md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             func,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          state_q;
    logic            func_q;      // 0 = MUL, 1 = DIV
    logic [WIDTH-1:0] acc_q;      // MUL accumulator / DIV partial remainder
    logic [WIDTH-1:0] mcand_q;    // MUL shifting multiplicand / DIV divisor
    logic [WIDTH-1:0] mplier_q;   // MUL shifting multiplier / DIV quotient-dividend shifter
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_lo_q;
    logic [WIDTH-1:0] res_hi_q;

    logic [WIDTH-1:0] rs;
    logic             ge;
    logic [WIDTH-1:0] acc_mul_d;
    logic [WIDTH-1:0] rem_div_d;
    logic [WIDTH-1:0] quo_div_d;
    logic             last_iter;
    logic             mul_last;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

    // ALU drive and per-iteration next values, all from registered state
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OP_ADD;
        rs        = {acc_q[WIDTH-2:0], mplier_q[WIDTH-1]};
        // The shifted-out remainder MSB makes this a WIDTH+1 bit compare
        ge        = ({acc_q[WIDTH-1], rs} >= {1'b0, mcand_q});
        acc_mul_d = mplier_q[0] ? alu_out : acc_q;
        rem_div_d = ge ? alu_out : rs;
        quo_div_d = {mplier_q[WIDTH-2:0], ge};
        last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MDSEQ_EARLY_EXIT_EN
        mul_last  = last_iter || (mplier_q[WIDTH-1:1] == '0);
`else
        mul_last  = last_iter;
`endif
        if (state_q == S_RUN) begin
            if (!func_q) begin
                alu_a  = acc_q;
                alu_b  = mcand_q;
                alu_op = OP_ADD;
            end else begin
                alu_a  = rs;
                alu_b  = mcand_q;
                alu_op = OP_SUB;
            end
        end
    end

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            func_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        func_q   <= func;
                        acc_q    <= '0;
                        mcand_q  <= src_b;
                        mplier_q <= src_a;
                        cnt_q    <= '0;
                        if (!func) begin
                            // MUL: multiplier is src_b, multiplicand is src_a
                            mcand_q  <= src_a;
                            mplier_q <= src_b;
                        end
                        if (func && (src_b == '0)) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            res_lo_q <= '1;
                            res_hi_q <= src_a;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!func_q) begin
                        acc_q    <= acc_mul_d;
                        mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                        if (mul_last) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            res_lo_q <= acc_mul_d;
                            res_hi_q <= '0;
                        end
                    end else begin
                        acc_q    <= rem_div_d;
                        mplier_q <= quo_div_d;
                        if (last_iter) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            res_lo_q <= quo_div_d;
                            res_hi_q <= rem_div_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Self-checking bench for alu_md_sequencer: fixed vector table, random
// operations against an arithmetic reference, and handshake corner cases.
module tb_alu_md_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         func;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Single-cycle ALU sharing the sequencer's interface
    assign alu_out = (alu_op == 2'b01) ? (alu_a - alu_b) : (alu_a + alu_b);

    always #5 clk = ~clk;

    alu_md_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .func      (func),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out)
    );

    typedef struct {
        logic         f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycle (after the start edge) in which done is expected
    function automatic int exp_lat(input logic f, input logic [W-1:0] b);
        int lat;
        lat = W + 1;
        if (f && b == 0) lat = 1;
`ifdef MDSEQ_EARLY_EXIT_EN
        if (!f) begin
            int iters;
            iters = 1;
            for (int i = 0; i < W; i++) if (b[i]) iters = i + 1;
            lat = iters + 1;
        end
`endif
        return lat;
    endfunction

    function automatic logic [2*W-1:0] model(input logic f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        if (!f) begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return {{W{1'b0}}, prod[W-1:0]};
        end
        if (b == 0) return {a, {W{1'b1}}};
        return {a % b, a / b};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check latency, handshake, ALU usage and results
    task automatic run_op(input logic f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] elo, input logic [W-1:0] ehi, input string tag);
        int  cyc;
        int  lat;
        bit  seen;
        bit  busy_bad;
        bit  op_bad;
        start = 1'b1; func = f; src_a = a; src_b = b;
        tick();
        start = 1'b0;
        cyc = 1; seen = 0; busy_bad = 0; op_bad = 0; lat = 0;
        while (!seen && cyc <= 80) begin
            if (done === 1'b1) begin
                seen = 1;
                lat = cyc;
            end else begin
                if (busy !== 1'b1) busy_bad = 1;
                if (alu_op !== (f ? 2'b01 : 2'b00)) op_bad = 1;
                tick();
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, W'(seen), W'(1));
        if (seen) begin
            chk({tag, "_latency"}, W'(lat), W'(exp_lat(f, b)));
            chk({tag, "_busy_run"}, W'(busy_bad), W'(0));
            chk({tag, "_alu_op_run"}, W'(op_bad), W'(0));
            chk({tag, "_busy_in_done"}, W'(busy), W'(0));
            chk({tag, "_alu_idle"}, alu_a | alu_b | W'(alu_op), W'(0));
            chk({tag, "_lo"}, result_lo, elo);
            chk({tag, "_hi"}, result_hi, ehi);
            tick();
            chk({tag, "_done_pulse"}, W'(done), W'(0));
            chk({tag, "_lo_hold"}, result_lo, elo);
        end
    endtask

    vec_t vecs[9];

    initial begin
        int ndone;
        int done_cyc;
        logic [2*W-1:0] m;
        logic           rf;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;

        vecs[0] = '{1'b0, 32'd7,         32'd6,         32'd42,        32'd0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFE,  32'd0};
        vecs[2] = '{1'b0, 32'h00010000,  32'h00010000,  32'd0,         32'd0};
        vecs[3] = '{1'b0, 32'd0,         32'd12345,     32'd0,         32'd0};
        vecs[4] = '{1'b1, 32'd100,       32'd7,         32'd14,        32'd2};
        vecs[5] = '{1'b1, 32'hFFFFFFFF,  32'h80000001,  32'd1,         32'h7FFFFFFE};
        vecs[6] = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5};
        vecs[7] = '{1'b1, 32'd3,         32'd10,        32'd0,         32'd3};
        vecs[8] = '{1'b1, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0};

        rst = 1'b1; start = 1'b0; func = 1'b0; src_a = '0; src_b = '0;
        repeat (3) tick();
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_lo", result_lo, W'(0));
        chk("reset_hi", result_hi, W'(0));
        chk("reset_alu", alu_a | alu_b | W'(alu_op), W'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, $sformatf("vec%0d", i));

        // start pulses during RUN and during DONE must be ignored
        start = 1'b1; func = 1'b0; src_a = 32'd7; src_b = 32'h80000006;
        tick();
        start = 1'b0;
        ndone = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
            if (cyc == 5 || cyc == 33) begin
                start = 1'b1; func = 1'b1; src_a = 32'd99; src_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("ignore_start_ndone", W'(ndone), W'(1));
        chk("ignore_start_cycle", W'(done_cyc), W'(33));
        chk("ignore_start_lo", result_lo, 32'h8000002A);
        chk("ignore_start_hi", result_hi, W'(0));
        chk("ignore_start_idle", W'(busy), W'(0));

        // reset in cycle 10 of a divide aborts it
        start = 1'b1; func = 1'b1; src_a = 32'd100; src_b = 32'd7;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_lo", result_lo, W'(0));
        chk("abort_hi", result_hi, W'(0));
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("abort_no_done", W'(ndone), W'(0));
        run_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, "after_abort");

        // random operations against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            rf = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            m = model(rf, ra, rb);
            run_op(rf, ra, rb, m[W-1:0], m[2*W-1:W], $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
